// File: rtl/scoreboarded_register_file.sv
// -----------------------------------------------------------------------------
// scoreboarded_register_file
//
// Purpose:
//   Integer register file with READ_PORTS combinational read ports, one write
//   port and a per-register busy scoreboard. Decode reserves a destination
//   register, which sets its busy bit. Writeback writes the register and
//   releases the reservation. A hardware clear sequencer zeroes the array
//   after reset or on request. Register 0 always reads as zero and is never
//   busy.
//
// Optional feature (macro WRITE_BYPASS_EN):
//   When defined, a read port that addresses the register being written in
//   the same cycle returns writeData combinationally. Its busy flag then
//   reflects only a same-cycle reserve of that address.
//   When undefined, reads return the pre-edge array contents.
//
// Ports:
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-high reset
//   clearRequest      in   pulse: restart the clear sweep
//   ready             out  1 = array valid, accesses honoured
//   readAddress       in   READ_PORTS*AW, port p = [p*AW +: AW]
//   readData          out  READ_PORTS*XLEN, port p = [p*XLEN +: XLEN]
//   readBusy          out  READ_PORTS, 1 = addressed register has a pending write
//   reserveEnable     in   mark reserveAddress busy
//   reserveAddress    in   register to reserve
//   destinationEnable in   writeback write enable
//   writeAddress      in   write target
//   writeData         in   write value
// -----------------------------------------------------------------------------
module scoreboarded_register_file #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int READ_PORTS = 2,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clearRequest,
  output logic                         ready,
  input  logic [READ_PORTS*AW-1:0]     readAddress,
  output logic [READ_PORTS*XLEN-1:0]   readData,
  output logic [READ_PORTS-1:0]        readBusy,
  input  logic                         reserveEnable,
  input  logic [AW-1:0]                reserveAddress,
  input  logic                         destinationEnable,
  input  logic [AW-1:0]                writeAddress,
  input  logic [XLEN-1:0]              writeData
);

  localparam logic STATE_CLEAR = 1'b0;
  localparam logic STATE_IDLE  = 1'b1;

  localparam logic [AW-1:0] FIRST_INDEX = AW'(1);
  localparam logic [AW-1:0] LAST_INDEX  = AW'(NUM_REGS - 1);

  logic                state_q, state_d;
  logic [AW-1:0]       clearIndex_q, clearIndex_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]     regs_q [NUM_REGS];

  logic writeFire;
  logic reserveFire;

  // A clear request in the same cycle drops any write or reserve.
  assign writeFire   = (state_q == STATE_IDLE) && !clearRequest &&
                       destinationEnable && (writeAddress != '0);
  assign reserveFire = (state_q == STATE_IDLE) && !clearRequest &&
                       reserveEnable && (reserveAddress != '0);

  assign ready = (state_q == STATE_IDLE);

  // Next-state logic for the sequencer and the scoreboard.
  // The release is applied before the reserve, so a reserve to the same
  // address in the same cycle leaves the busy bit set.
  always_comb begin
    state_d      = state_q;
    clearIndex_d = clearIndex_q;
    busy_d       = busy_q;
    if (clearRequest) begin
      state_d      = STATE_CLEAR;
      clearIndex_d = FIRST_INDEX;
      busy_d       = '0;
    end else if (state_q == STATE_CLEAR) begin
      clearIndex_d = clearIndex_q + FIRST_INDEX;
      if (clearIndex_q == LAST_INDEX) begin
        state_d = STATE_IDLE;
      end
    end else begin
      if (writeFire) begin
        busy_d[writeAddress] = 1'b0;
      end
      if (reserveFire) begin
        busy_d[reserveAddress] = 1'b1;
      end
    end
  end

  // Control state.
  // Reset restarts the sweep from register 1 and drops every reservation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= STATE_CLEAR;
      clearIndex_q <= FIRST_INDEX;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      clearIndex_q <= clearIndex_d;
      busy_q       <= busy_d;
    end
  end

  // Storage array.
  // The array has no reset; the sweep zeroes it. Entry 0 is never written,
  // and the read path masks it.
  always_ff @(posedge clock) begin
    if (state_q == STATE_CLEAR) begin
      regs_q[clearIndex_q] <= '0;
    end else if (writeFire) begin
      regs_q[writeAddress] <= writeData;
    end
  end

  // Combinational read ports.
  // All ports read zero and not-busy while the sweep runs, and for address 0.
  always_comb begin
    readData = '0;
    readBusy = '0;
    if (state_q == STATE_IDLE) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (readAddress[p*AW +: AW] != '0) begin
          readData[p*XLEN +: XLEN] = regs_q[readAddress[p*AW +: AW]];
          readBusy[p]              = busy_q[readAddress[p*AW +: AW]];
`ifdef WRITE_BYPASS_EN
          if (destinationEnable && (writeAddress == readAddress[p*AW +: AW])) begin
            readData[p*XLEN +: XLEN] = writeData;
            readBusy[p] = reserveEnable && (reserveAddress == readAddress[p*AW +: AW]);
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// -----------------------------------------------------------------------------
// tb_scoreboarded_register_file
//
// Purpose:
//   Directed testbench for scoreboarded_register_file with the default
//   parameters (XLEN=32, NUM_REGS=32, READ_PORTS=2). It covers:
//   - reset and clear-sweep timing
//   - reads, writes and reserves
//   - register 0 behaviour
//   - clear and reset interaction
//   - same-cycle bypass, with or without WRITE_BYPASS_EN
// -----------------------------------------------------------------------------
module tb_scoreboarded_register_file;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int READ_PORTS = 2;
  localparam int AW         = 5;

  logic                       clock;
  logic                       reset;
  logic                       clearRequest;
  logic                       ready;
  logic [READ_PORTS*AW-1:0]   readAddress;
  logic [READ_PORTS*XLEN-1:0] readData;
  logic [READ_PORTS-1:0]      readBusy;
  logic                       reserveEnable;
  logic [AW-1:0]              reserveAddress;
  logic                       destinationEnable;
  logic [AW-1:0]              writeAddress;
  logic [XLEN-1:0]            writeData;

  int testsRun  = 0;
  int testsFail = 0;
  int cnt;

  scoreboarded_register_file #(
    .XLEN(XLEN),
    .NUM_REGS(NUM_REGS),
    .READ_PORTS(READ_PORTS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .clearRequest(clearRequest),
    .ready(ready),
    .readAddress(readAddress),
    .readData(readData),
    .readBusy(readBusy),
    .reserveEnable(reserveEnable),
    .reserveAddress(reserveAddress),
    .destinationEnable(destinationEnable),
    .writeAddress(writeAddress),
    .writeData(writeData)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the write, reserve and clear inputs.
  task automatic applyStimulus(input logic de, input logic [AW-1:0] wa,
                               input logic [XLEN-1:0] wd, input logic re,
                               input logic [AW-1:0] ra, input logic cr);
    destinationEnable = de;
    writeAddress      = wa;
    writeData         = wd;
    reserveEnable     = re;
    reserveAddress    = ra;
    clearRequest      = cr;
  endtask

  // Set the addresses of both read ports.
  task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    readAddress = {a1, a0};
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Count the sample points at which ready is still low.
  // The count is bounded so that a stuck design cannot hang the run.
  task automatic waitReady(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd0, 5'd0);
    #3;
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_rd0", readData[31:0], 32'd0);
    checkOutput("reset_busy", 32'(readBusy), 32'd0);

    // Reset release and the first sweep.
    @(negedge clock);
    reset = 1'b0;
    waitReady(cnt);
    checkOutput("init_sweep_cycles", 32'(cnt), 32'd31);
    for (int i = 1; i < NUM_REGS; i++) begin
      setRead(5'(i), 5'(i));
      #1;
      checkOutput("init_zero_p0", readData[31:0], 32'd0);
      checkOutput("init_zero_p1", readData[63:32], 32'd0);
      checkOutput("init_busy", 32'(readBusy), 32'd0);
    end

    // Write x5, then read it back alongside x0.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd5, 5'd0);
    #1;
    checkOutput("x5_data", readData[31:0], 32'hDEADBEEF);
    checkOutput("x0_data", readData[63:32], 32'd0);
    checkOutput("x5_notbusy", 32'(readBusy), 32'd0);

    // Reserve x7, then release it with a write.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd7, 5'd7);
    #1;
    checkOutput("x7_busy", 32'(readBusy), 32'd3);
    applyStimulus(1'b1, 5'd7, 32'h12, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("x7_released", 32'(readBusy), 32'd0);
    checkOutput("x7_data", readData[31:0], 32'h12);

    // Reserve and write x9 in the same cycle.
    applyStimulus(1'b1, 5'd9, 32'h34, 1'b1, 5'd9, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd9, 5'd5);
    #1;
    checkOutput("x9_data", readData[31:0], 32'h34);
    checkOutput("x9_busy", 32'(readBusy), 32'd1);

    // Register 0 ignores both writes and reserves.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd0, 5'd0);
    #1;
    checkOutput("x0_after_write", readData[31:0], 32'd0);
    checkOutput("x0_busy", 32'(readBusy), 32'd0);

    // A same-cycle write while a port addresses the target.
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 1'b0);
    setRead(5'd5, 5'd3);
    #1;
    checkOutput("bypass_other_port", readData[31:0], 32'hDEADBEEF);
`ifdef WRITE_BYPASS_EN
    checkOutput("bypass_p1", readData[63:32], 32'hA5A5A5A5);
`else
    checkOutput("nobypass_p1", readData[63:32], 32'd0);
`endif
    checkOutput("bypass_busy", 32'(readBusy), 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("x3_after_edge", readData[63:32], 32'hA5A5A5A5);

    // A clear request, with writes and reserves attempted during the sweep.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
    setRead(5'd5, 5'd9);
    for (int k = 0; k < 10; k++) begin
      checkOutput("clear_ready", 32'(ready), 32'd0);
      checkOutput("clear_rd_masked", readData[31:0], 32'd0);
      checkOutput("clear_busy_masked", 32'(readBusy), 32'd0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    waitReady(cnt);
    checkOutput("clear_remaining", 32'(cnt), 32'd21);
    setRead(5'd3, 5'd9);
    #1;
    checkOutput("x3_cleared", readData[31:0], 32'd0);
    checkOutput("x9_cleared", readData[63:32], 32'd0);
    checkOutput("busy_cleared", 32'(readBusy), 32'd0);
    setRead(5'd5, 5'd7);
    #1;
    checkOutput("x5_cleared", readData[31:0], 32'd0);
    checkOutput("x7_cleared", readData[63:32], 32'd0);

    // A clear request during the sweep restarts it.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    waitReady(cnt);
    checkOutput("restart_cycles", 32'(cnt), 32'd31);

    // Fill the array and reserve x10.
    for (int i = 1; i < NUM_REGS; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, '0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd10, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd20, 5'd10);
    #1;
    checkOutput("fill_x20", readData[31:0], 32'h1014);
    checkOutput("fill_x10", readData[63:32], 32'h100A);
    checkOutput("fill_busy", 32'(readBusy), 32'd2);

    // Clear requested together with a write and a reserve. Reset is then
    // asserted 10 cycles into the sweep.
    applyStimulus(1'b1, 5'd4, 32'h77, 1'b1, 5'd11, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("clear_win_ready", 32'(ready), 32'd0);
    repeat (9) tick();
    reset = 1'b1;
    #2;
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_rd", readData[31:0], 32'd0);
    @(negedge clock);
    reset = 1'b0;
    waitReady(cnt);
    checkOutput("midreset_sweep_cycles", 32'(cnt), 32'd31);
    for (int i = 1; i < NUM_REGS; i++) begin
      setRead(5'(i), 5'(NUM_REGS - i));
      #1;
      checkOutput("final_zero_p0", readData[31:0], 32'd0);
      checkOutput("final_zero_p1", readData[63:32], 32'd0);
      checkOutput("final_busy", 32'(readBusy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
